// File: rtl/ct_param_counter.sv
// ct_param_counter: up/down counter with load, programmable terminal value, wrap/saturate
// boundary handling, step size, enable prescaler and event/sticky-overflow flags.
module ct_param_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] max_val,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  evt,
  output logic                  at_term,
  output logic                  ovf_sticky
);
  localparam int NW = DATA_WIDTH + 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]         r_pre;
  logic [DATA_WIDTH-1:0] r_count, w_nxt;
  logic                  r_evt, r_at_term, r_ovf;
  logic [NW-1:0]         w_step, w_cnt, w_max, w_sum, w_diff;
  logic                  w_pre_last, w_act, w_up_evt, w_dn_evt, w_evt;
  // Arithmetic is one bit wider than the count so neither the sum nor the borrow is lost.
  assign w_step     = NW'(step);
  assign w_cnt      = {1'b0, r_count};
  assign w_max      = {1'b0, max_val};
  assign w_sum      = w_cnt + w_step;
  assign w_diff     = w_cnt - w_step;
  assign w_pre_last = r_pre == PW'(PRESCALE - 1);
  assign w_act      = en && w_pre_last && step != '0;
  assign w_up_evt   = w_sum > w_max;
  assign w_dn_evt   = w_step > w_cnt;
  assign w_evt      = !ld && w_act && (up_dn ? w_up_evt : w_dn_evt);
  always_comb begin
    w_nxt = r_count;
    if (ld)
      w_nxt = data > max_val ? max_val : data;
    else if (w_act && up_dn)
      w_nxt = w_up_evt ? (sat_mode ? max_val : '0) : w_sum[DATA_WIDTH-1:0];
    else if (w_act)
      // a count left above a lowered max_val is pulled back into range without an event
      w_nxt = w_dn_evt ? (sat_mode ? '0 : max_val)
                       : (w_diff > w_max ? max_val : w_diff[DATA_WIDTH-1:0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_evt     <= 1'b0;
      r_at_term <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_pre     <= ld ? '0 : en ? (w_pre_last ? '0 : r_pre + PW'(1)) : r_pre;
      r_count   <= w_nxt;
      r_evt     <= w_evt;
      r_at_term <= up_dn ? w_nxt == max_val : w_nxt == '0;
      r_ovf     <= w_evt | (r_ovf & ~clr_ovf);
    end
  end
  assign count      = r_count;
  assign evt        = r_evt;
  assign at_term    = r_at_term;
  assign ovf_sticky = r_ovf;
endmodule

// File: doc/ct_param_counter.md
Name: ct_param_counter

Overview:
- Parametrised up/down counter with a load channel, programmable terminal value, selectable wrap or saturate mode, step size, enable prescaler, and event/sticky-overflow flags.
- Next generation of the counter DUT driven by the counter parameter-input VIP; ld/data keep the same meaning as on that agent.
- Sits under the counter testbench as the DUT, and is reusable as a general timer/counter primitive.

Parameters:
- DATA_WIDTH, 8, width of data, max_val and count.
- STEP_WIDTH, 4, width of step.
- PRESCALE, 1, number of enabled cycles per counting action; minimum 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- ld  input  1  load strobe.
- data  input  DATA_WIDTH  load value.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap.
- step  input  STEP_WIDTH  increment/decrement amount; step=0 means hold.
- max_val  input  DATA_WIDTH  terminal (top) value; range is 0..max_val.
- clr_ovf  input  1  clears ovf_sticky.
- count  output  DATA_WIDTH  registered counter value.
- evt  output  1  one-cycle pulse in the cycle after a boundary event (wrap or saturate clip).
- at_term  output  1  registered; 1 when count==max_val (up) or count==0 (down), evaluated on the post-update count and current up_dn.
- ovf_sticky  output  1  set by any boundary event; held until cleared.

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low. Reset forces count=0, evt=0, ovf_sticky=0, prescaler=0 and at_term=0, with no dependency on clk; it may assert mid-operation.
- Priority per cycle: ld > counting action > hold.
- ld=1: count <= min(data, max_val). Prescaler cleared. evt=0. No ovf change. Takes effect even if en=1.
- Prescaler: counts en=1 cycles from 0 to PRESCALE-1. A counting action occurs on the en cycle where prescaler==PRESCALE-1, and the prescaler then returns to 0. With PRESCALE=1 every en cycle is an action. en=0 freezes the prescaler.
- Counting action, up: nxt = count + step, computed at DATA_WIDTH+1 bits.
  - If nxt <= max_val: count <= nxt.
  - Otherwise it is a boundary event: wrap mode gives count <= 0; saturate mode gives count <= max_val.
- Counting action, down:
  - If step <= count: count <= count - step.
  - Otherwise it is a boundary event: wrap mode gives count <= max_val; saturate mode gives count <= 0.
- Saturate mode already at the bound: a further step that would cross it is a boundary event (evt pulses, count unchanged). step=0 is never an event.
- count > max_val can arise when max_val is lowered at runtime.
  - Next up action: boundary event.
  - Next down action: normal subtraction; if the result is still > max_val, count is clamped to max_val without an event.
- evt: registered. Asserted exactly one cycle after the event edge, i.e. concurrent with the updated count. Consecutive events give consecutive pulses.
- ovf_sticky: set on an event. clr_ovf clears it; set wins when both occur in the same cycle.
- Latency: inputs sampled at posedge N; count, evt and at_term valid after posedge N.
- Width rules: step is zero-extended to DATA_WIDTH+1 bits; no truncation occurs in the compare.
- max_val=0: every nonzero-step action is an event and count stays 0.

Test Plan:
1. Reset then load: rst_n low 3 cycles, release; ld=1, data=0x20, max_val=0xFF -> count=0x20 next cycle; evt=0; ovf_sticky=0.
2. Up wrap, PRESCALE=1, DATA_WIDTH=8: count=0xFD, max_val=0xFF, step=2, en=1, sat_mode=0.
   - Expected sequence: 0xFF, then 0x00 with evt=1 and ovf_sticky=1, then 0x02 with evt=0.
3. Down saturate: count=3, step=2, up_dn=0, sat_mode=1, en held.
   - Expected sequence: 1, 0 (evt=1), 0 (evt=1), 0 (evt=1).
   - clr_ovf=1 in the same cycle as an event leaves ovf_sticky=1.
4. Prescaler, PRESCALE=4: en=1 for 8 cycles with step=1 from count=0 -> count=1 after the 4th enabled cycle, 2 after the 8th. An en=0 gap in between does not reset progress. ld mid-run restarts the prescaler.
5. Runtime max change: count=0x50, max_val changed to 0x30.
   - Up action: wrap mode gives count=0 with evt=1.
   - Repeat with a down action, step=1: count=0x30, no evt.
   - Separately, ld data=0x40 with max_val=0x30 -> count=0x30.
6. Async reset mid-count: assert rst_n between clock edges while en=1 and evt=1 -> count=0, evt=0, ovf_sticky=0 immediately. The first action after release starts from 0 with the prescaler at 0.
